// File: rtl/p_2x32_seq_pkg.sv
// Shared constants and state encoding for the P_2x32 sequencer.
package p_2x32_seq_pkg;

  localparam int MSB         = 31;
  localparam int N_LOAD      = 31;
  localparam int EK_WORDS    = 18;
  localparam int CNT_PD_ADDR = 19;
  localparam int CNT_PN_ADDR = 18;

  localparam logic INPUT_DIN = 1'b1;
  localparam logic INPUT_X   = 1'b0;

  localparam logic [4:0] LAST_LOAD_WC = 5'(N_LOAD - 1);
  localparam logic [4:0] LAST_EK_WC   = 5'(EK_WORDS - 1);
  localparam logic [4:0] CNT_PD_A     = 5'(CNT_PD_ADDR);
  localparam logic [4:0] CNT_PN_A     = 5'(CNT_PN_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_COPY_P   = 3'd2,
    ST_COPY_CNT = 3'd3,
    ST_WAIT_ZF  = 3'd4,
    ST_READY    = 3'd5,
    ST_DONE     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/p_2x32_seq.sv
// Control sequencer for P_2x32: job load into PD, EK/counter copy into PN, round countdown.
// Optional P_SEQ_ROUND_COUNT_EN adds the saturating 'rounds' output.
module p_2x32_seq
  import p_2x32_seq_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic [MSB:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           iter_req,
  output logic           iter_rdy,
  output logic           done,
  input  logic           done_ack,
  input  logic [MSB:0]   PD_out,
  input  logic           ZF,
  input  logic           B31,
  output logic [4:0]     PD_addr,
  output logic           PD_wr_en,
  output logic [MSB:0]   din,
  output logic           PS_input_select,
  output logic           decr,
  output logic [4:0]     PN_wr_addr,
  output logic [4:0]     PN_addr,
  output logic           PN_wr_en,
  output logic           ZF_wr_en,
  output logic           b31_flag
`ifdef P_SEQ_ROUND_COUNT_EN
  ,
  output logic [31:0]    rounds
`endif
);

  seq_state_e state_q, state_d;
  logic [4:0] wc_q, wc_d;
  logic       b31_flag_q;
  // Holds every enable low from reset assertion until the first edge after release.
  logic       rst_hold_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wc_q       <= '0;
      b31_flag_q <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      rst_hold_q <= 1'b0;
      if (state_q == ST_WAIT_ZF) b31_flag_q <= B31;
    end
  end

  always_comb begin
    state_d         = state_q;
    wc_d            = wc_q;
    in_ready        = 1'b0;
    PD_addr         = wc_q;
    PD_wr_en        = 1'b0;
    din             = PD_out;
    PS_input_select = INPUT_X;
    decr            = 1'b0;
    PN_wr_addr      = wc_q;
    PN_addr         = CNT_PN_A;
    PN_wr_en        = 1'b0;
    ZF_wr_en        = 1'b0;
    if (!rst_hold_q) begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            PD_wr_en = 1'b1;
            din      = in_data;
            if (wc_q == LAST_LOAD_WC) begin
              wc_d    = '0;
              state_d = ST_COPY_P;
            end else begin
              wc_d    = wc_q + 5'd1;
              state_d = ST_LOAD;
            end
          end
        end
        ST_COPY_P: begin
          PS_input_select = INPUT_DIN;
          PN_wr_en        = 1'b1;
          if (wc_q == LAST_EK_WC) begin
            wc_d    = '0;
            state_d = ST_COPY_CNT;
          end else begin
            wc_d = wc_q + 5'd1;
          end
        end
        ST_COPY_CNT: begin
          PD_addr         = CNT_PD_A;
          PS_input_select = INPUT_DIN;
          PN_wr_addr      = CNT_PN_A;
          PN_wr_en        = 1'b1;
          ZF_wr_en        = 1'b1;
          state_d         = ST_WAIT_ZF;
        end
        ST_WAIT_ZF: begin
          // ZF reflects the value written on the previous cycle.
          state_d = ZF ? ST_DONE : ST_READY;
        end
        ST_READY: begin
          if (iter_req) begin
            decr       = 1'b1;
            PN_wr_addr = CNT_PN_A;
            PN_wr_en   = 1'b1;
            ZF_wr_en   = 1'b1;
            state_d    = ST_WAIT_ZF;
          end
        end
        ST_DONE: begin
          if (done_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign iter_rdy = (state_q == ST_READY);
  assign done     = (state_q == ST_DONE);
  assign b31_flag = b31_flag_q;

`ifdef P_SEQ_ROUND_COUNT_EN
  logic [31:0] rounds_q;
  logic        job_start;

  assign job_start = (state_q == ST_IDLE) && in_ready && in_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rounds_q <= '0;
    end else if (job_start) begin
      rounds_q <= '0;
    end else if (decr && PN_wr_en && (rounds_q != 32'hFFFF_FFFF)) begin
      rounds_q <= rounds_q + 32'd1;
    end
  end

  assign rounds = rounds_q;
`endif

endmodule

// File: tb/tb_p_2x32_seq.sv
// Self-checking bench for p_2x32_seq with a behavioural P_2x32 datapath alongside.
module tb_p_2x32_seq;
  import p_2x32_seq_pkg::*;

  logic        CLK, RST;
  logic [31:0] in_data;
  logic        in_valid, in_ready, iter_req, iter_rdy, done, done_ack;
  logic [31:0] PD_out, din;
  logic        ZF, B31;
  logic [4:0]  PD_addr, PN_wr_addr, PN_addr;
  logic        PD_wr_en, PS_input_select, decr, PN_wr_en, ZF_wr_en, b31_flag;
`ifdef P_SEQ_ROUND_COUNT_EN
  logic [31:0] rounds;
`endif

  p_2x32_seq dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .iter_req(iter_req), .iter_rdy(iter_rdy), .done(done), .done_ack(done_ack),
    .PD_out(PD_out), .ZF(ZF), .B31(B31), .PD_addr(PD_addr), .PD_wr_en(PD_wr_en),
    .din(din), .PS_input_select(PS_input_select), .decr(decr), .PN_wr_addr(PN_wr_addr),
    .PN_addr(PN_addr), .PN_wr_en(PN_wr_en), .ZF_wr_en(ZF_wr_en), .b31_flag(b31_flag)
`ifdef P_SEQ_ROUND_COUNT_EN
    , .rounds(rounds)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural P_2x32: async-read PD, PN with decrement path, ZF/B31 flags.
  logic [31:0] pd_mem [0:31];
  logic [31:0] pn_mem [0:31];
  logic        zf_q, b31_q;
  logic [31:0] pn_wval;

  assign PD_out  = pd_mem[PD_addr];
  assign pn_wval = decr ? (pn_mem[PN_addr] - 32'd1)
                        : ((PS_input_select == INPUT_DIN) ? din : 32'h0);
  assign ZF  = zf_q;
  assign B31 = b31_q;

  always @(posedge CLK) begin
    if (PD_wr_en) pd_mem[PD_addr] <= din;
    if (PN_wr_en) pn_mem[PN_wr_addr] <= pn_wval;
    if (ZF_wr_en) begin
      zf_q  <= (pn_wval == 32'd0);
      b31_q <= pn_wval[31];
    end
  end

  // Write monitors: PD writes must be contiguous per job and never on stall cycles.
  int pd_wr_total = 0, pd_addr_bad = 0, pd_stall_bad = 0, decr_total = 0;
  always @(posedge CLK) begin
    if (PD_wr_en) begin
      pd_wr_total <= pd_wr_total + 1;
      if (PD_addr != 5'(pd_wr_total % 31)) pd_addr_bad <= pd_addr_bad + 1;
      if (!in_valid) pd_stall_bad <= pd_stall_bad + 1;
    end
    if (decr && PN_wr_en) decr_total <= decr_total + 1;
  end

  int n_pass = 0, n_total = 0;
  logic [31:0] job_w [0:30];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_job(input int max_cnt);
    for (int i = 0; i < 31; i++) job_w[i] = $urandom;
    job_w[19] = $urandom_range(0, max_cnt);
  endtask

  // mode 0: in_valid always high; 1: alternating 1,0,1,0; 2: random
  task automatic load_words(input int mode, input bit noise);
    int idx, cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < 31 && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data  = job_w[idx];
      iter_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      acc = in_valid && in_ready;
      step;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    iter_req = 1'b0;
    chk("load_beats", idx, 31);
  endtask

  task automatic do_job(input string tag, input int mode, input bit noise, input int max_it);
    int wr0, dec0, n, cnt, ek_bad, addr_bad0, stall_bad0;
    wr0 = pd_wr_total;
    dec0 = decr_total;
    addr_bad0 = pd_addr_bad;
    stall_bad0 = pd_stall_bad;
    load_words(mode, noise);
    n = 0;
    while (!(iter_rdy || done) && n < 60) begin
      iter_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step;
      n++;
    end
    iter_req = 1'b0;
    chk({tag, " load_to_ready"}, n, 20);
    chk({tag, " pd_writes"}, pd_wr_total - wr0, 31);
    chk({tag, " pd_addr_contig"}, pd_addr_bad - addr_bad0, 0);
    chk({tag, " pd_stall_write"}, pd_stall_bad - stall_bad0, 0);
    chk({tag, " no_decr_in_load"}, decr_total - dec0, 0);
    ek_bad = 0;
    for (int i = 0; i < 18; i++) if (pn_mem[i] !== job_w[i]) ek_bad++;
    chk({tag, " pn_ek_copy"}, ek_bad, 0);
    chk({tag, " pn_counter"}, pn_mem[18], job_w[19]);
    chk({tag, " b31_flag"}, b31_flag, job_w[19][31]);
    chk({tag, " done_if_zero"}, done, job_w[19] == 0);
    if (job_w[19] > 32'(max_it)) return;
    cnt = int'(job_w[19]);
    for (int k = 1; k <= cnt; k++) begin
      chk({tag, " iter_rdy"}, iter_rdy, 1);
      iter_req = 1'b1;
      step;
      iter_req = 1'b0;
      n = 1;
      while (!(iter_rdy || done) && n < 20) begin
        step;
        n++;
      end
      chk({tag, " req_latency"}, n, 2);
      chk({tag, " pn_counter_dec"}, pn_mem[18], 32'(cnt - k));
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " iter_rdy_low"}, iter_rdy, 0);
    chk({tag, " decrements"}, decr_total - dec0, cnt);
`ifdef P_SEQ_ROUND_COUNT_EN
    chk({tag, " rounds"}, rounds, cnt);
`endif
    iter_req = 1'b1;
    repeat (3) step;
    iter_req = 1'b0;
    chk({tag, " req_ignored_done"}, decr_total - dec0, cnt);
    chk({tag, " done_held"}, done, 1);
    done_ack = 1'b1;
    step;
    done_ack = 1'b0;
    chk({tag, " done_release"}, done, 0);
    chk({tag, " idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    iter_req = 1'b0;
    done_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    in_valid = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst pd_wr_en", PD_wr_en, 0);
    chk("rst iter_rdy", iter_rdy, 0);
    chk("rst done", done, 0);
    chk("rst b31_flag", b31_flag, 0);
    in_valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("post_rst in_ready", in_ready, 0);
    step;
    chk("idle in_ready", in_ready, 1);

    // Directed job: w[i]=0x1000+i, iter_count 3
    for (int i = 0; i < 31; i++) job_w[i] = 32'h1000 + 32'(i);
    job_w[19] = 32'd3;
    do_job("job_a", 0, 0, 8);
    do_job("job_a_gaps", 1, 1, 8);

    job_w[19] = 32'd0;
    do_job("zero_iter", 2, 1, 8);

    for (int j = 0; j < 4; j++) begin
      rand_job(3);
      do_job("rand", 2, 1, 8);
    end

    // Large count with bit31 set: check flag then recover via reset from READY
    rand_job(0);
    job_w[19] = 32'h8000_0005;
    do_job("b31", 0, 0, 8);
    chk("b31 iter_rdy", iter_rdy, 1);
    RST = 1'b1;
    step;
    RST = 1'b0;
    step;
    chk("b31 reset flag", b31_flag, 0);
    chk("b31 reset iter_rdy", iter_rdy, 0);

    // Reset in the middle of COPY_P (wc=7)
    rand_job(3);
    load_words(0, 0);
    repeat (7) step;
    chk("copy_p active", PN_wr_en, 1);
    chk("copy_p addr", PN_wr_addr, 7);
    RST = 1'b1;
    #1;
    chk("mid_rst pn_wr_en", PN_wr_en, 0);
    chk("mid_rst pd_wr_en", PD_wr_en, 0);
    chk("mid_rst zf_wr_en", ZF_wr_en, 0);
    chk("mid_rst in_ready", in_ready, 0);
    chk("mid_rst decr", decr, 0);
    repeat (2) step;
    RST = 1'b0;
    #1;
    chk("mid_rst release in_ready", in_ready, 0);
    step;
    chk("mid_rst idle in_ready", in_ready, 1);
    rand_job(3);
    do_job("after_rst", 2, 1, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
